// File: rtl/count_mon_pkg.sv
// Shared types and constants for the counter sequence monitor.
package count_mon_pkg;

    typedef enum logic [1:0] {IDLE, SYNC, TRACK} state_t;

    typedef enum logic [1:0] {
        HIT  = 2'd0,
        WRAP = 2'd1,
        ERR  = 2'd2
    } evt_code_t;

    localparam int COUNT_W = 8;
    localparam int EVT_W   = 2 + COUNT_W;

    // The counter either steps by one or lands on zero the cycle after its sync reset.
    function automatic logic [COUNT_W-1:0] next_expected(input logic [COUNT_W-1:0] prev,
                                                         input logic               rst_q);
        return rst_q ? '0 : prev + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Small synchronous FIFO for monitor events; flush empties it in one cycle.
module evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fill;
    logic             do_push;
    logic             do_pop;

    assign full    = (fill == (AW+1)'(DEPTH));
    assign empty   = (fill == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot this very edge, so a push into a full queue still lands.
    assign do_push = push && (!full || do_pop);

    // NOTE: storage carries no reset; dout is forced to zero while empty so stale words never leak.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = empty ? '0 : mem[rd_ptr];

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Watches an upstream 8-bit counter for sequence errors, wraps and threshold hits,
// and queues one coded event per cycle for a ready/valid consumer.
module count_monitor
    import count_mon_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       count,
    input  logic             cnt_reset,
    input  logic             enable,
    input  logic [7:0]       threshold,
    input  logic             clr,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [EVT_W-1:0] evt_data,
    output logic             err,
    output logic [7:0]       err_count,
    output logic             overflow
);

    state_t           state;
    logic [7:0]       prev;
    logic             rst_q;

    logic             checking;
    logic [7:0]       expected;
    logic             mismatch;
    logic             wrap_seen;
    logic             hit_seen;
    logic             evt_push;
    evt_code_t        evt_code;
    logic [EVT_W-1:0] evt_din;
    logic             evt_pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign checking  = (state == TRACK) && enable;
    assign expected  = next_expected(prev, rst_q);
    assign mismatch  = checking && (count != expected);
    assign wrap_seen = checking && (prev == 8'hFF) && (count == 8'h00) && !rst_q;
    assign hit_seen  = checking && (count == threshold) && (prev != threshold);

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        evt_push = 1'b0;
        evt_code = HIT;
        if (mismatch) begin
            evt_push = 1'b1;
            evt_code = ERR;
        end else if (wrap_seen) begin
            evt_push = 1'b1;
            evt_code = WRAP;
        end else if (hit_seen) begin
            evt_push = 1'b1;
            evt_code = HIT;
        end
    end

    assign evt_din   = {evt_code, count};
    assign evt_pop   = evt_valid && evt_ready;
    assign evt_valid = !fifo_empty;

    evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (evt_push),
        .pop     (evt_pop),
        .flush   (clr),
        .din     (evt_din),
        .dout    (evt_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            prev      <= '0;
            rst_q     <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            rst_q <= cnt_reset;

            if (!enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    state <= SYNC;
                    SYNC: begin
                        prev  <= count;
                        state <= TRACK;
                    end
                    TRACK:   prev <= count;
                    default: state <= IDLE;
                endcase
            end

            // Clear only touches status; the tracking FSM keeps running.
            if (clr) begin
                err       <= 1'b0;
                err_count <= '0;
                overflow  <= 1'b0;
            end else begin
                if (mismatch) begin
                    err <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                if (evt_push && fifo_full && !evt_pop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: expected events go into a scoreboard queue
// and a negedge monitor pops them as the DUT hands events to the consumer.
module tb_count_monitor;
    import count_mon_pkg::*;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b1;
    logic [7:0] count     = 8'd0;
    logic       cnt_reset = 1'b0;
    logic       enable    = 1'b0;
    logic [7:0] threshold = 8'd5;
    logic       clr       = 1'b0;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic [9:0] evt_data;
    logic       err;
    logic [7:0] err_count;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    count_monitor #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .count     (count),
        .cnt_reset (cnt_reset),
        .enable    (enable),
        .threshold (threshold),
        .clr       (clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .err       (err),
        .err_count (err_count),
        .overflow  (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one counter value for one rising edge; returns 1 time unit after the edge.
    task automatic cyc(input logic [7:0] v, input logic crst = 1'b0);
        count     = v;
        cnt_reset = crst;
        @(posedge clk);
        #1;
        cnt_reset = 1'b0;
    endtask

    function automatic logic [9:0] ev(input evt_code_t c, input logic [7:0] v);
        return {c, v};
    endfunction

    // Scoreboard monitor: compares each accepted event and holds data steady under stall.
    initial begin
        logic       stalled;
        logic [9:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
                stalled = 1'b0;
                if (exp_q.size() == 0) check("unexpected_event", 32'(evt_data), 32'h3FF);
                else                   check("evt_data", 32'(evt_data), 32'(exp_q.pop_front()));
            end else if (evt_valid === 1'b1) begin
                if (stalled) check("evt_data_stable", 32'(evt_data), 32'(held));
                stalled = 1'b1;
                held    = evt_data;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_data",  evt_data,  0);
        check("rst_err",       err,       0);
        check("rst_err_count", err_count, 0);
        check("rst_overflow",  overflow,  0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Free-running counter, threshold 5: one HIT on the first lap, then a WRAP.
        enable = 1'b1;
        cyc(8'd0);
        cyc(8'd1);
        for (int v = 2; v < 256; v++) begin
            if (v == 5) exp_q.push_back(ev(HIT, 8'd5));
            cyc(8'(v));
        end
        check("lap_err", err, 0);
        exp_q.push_back(ev(WRAP, 8'd0));
        cyc(8'd0);

        // Second lap up to 100, counter sync reset there; restart from 0 must not error.
        for (int v = 1; v <= 100; v++) begin
            if (v == 5) exp_q.push_back(ev(HIT, 8'd5));
            cyc(8'(v), v == 100);
        end
        threshold = 8'd250;
        for (int v = 0; v <= 10; v++) cyc(8'(v));
        check("cnt_reset_err",       err,       0);
        check("cnt_reset_err_count", err_count, 0);

        // Jump 10 -> 12 is a sequence error.
        exp_q.push_back(ev(ERR, 8'd12));
        cyc(8'd12);
        check("err_set",       err,       1);
        check("err_count_one", err_count, 1);

        // Holding the count at 12 is an error every cycle; the total saturates.
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(ev(ERR, 8'd12));
            cyc(8'd12);
            if (i == 252) check("err_count_254", err_count, 254);
        end
        check("err_count_sat", err_count, 255);

        // Clear coincides with another error detection: clear wins.
        clr = 1'b1;
        cyc(8'd12);
        clr = 1'b0;
        check("clr_evt_valid", evt_valid, 0);
        check("clr_err",       err,       0);
        check("clr_err_count", err_count, 0);
        cyc(8'd13);
        check("post_clr_err",  err,       0);

        // Stall the consumer and fill the queue with four errors.
        evt_ready = 1'b0;
        exp_q.push_back(ev(ERR, 8'd20)); cyc(8'd20);
        exp_q.push_back(ev(ERR, 8'd30)); cyc(8'd30);
        exp_q.push_back(ev(ERR, 8'd40)); cyc(8'd40);
        exp_q.push_back(ev(ERR, 8'd50)); cyc(8'd50);
        check("full_no_overflow", overflow, 0);
        // Push and pop together on a full queue both succeed.
        evt_ready = 1'b1;
        exp_q.push_back(ev(ERR, 8'd60)); cyc(8'd60);
        check("full_push_pop_overflow", overflow, 0);
        // Next error finds the queue full with no pop: dropped.
        evt_ready = 1'b0;
        cyc(8'd70);
        check("drop_overflow",  overflow,  1);
        check("drop_err_count", err_count, 6);
        evt_ready = 1'b1;
        for (int v = 71; v <= 76; v++) cyc(8'(v));
        check("drained_evt_valid", evt_valid, 0);
        check("overflow_sticky",   overflow,  1);
        clr = 1'b1;
        cyc(8'd77);
        clr = 1'b0;
        check("clr_overflow", overflow, 0);

        // Queue three events, then reset mid-operation: all are discarded at once.
        evt_ready = 1'b0;
        cyc(8'd80);
        cyc(8'd90);
        cyc(8'd100);
        check("queued_evt_valid", evt_valid, 1);
        reset_n = 1'b0;
        #2;
        check("async_rst_evt_valid", evt_valid, 0);
        check("async_rst_evt_data",  evt_data,  0);
        check("async_rst_err",       err,       0);
        check("async_rst_err_count", err_count, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        evt_ready = 1'b1;

        // From IDLE: one SYNC cycle captures the count before any checking.
        cyc(8'd50);
        cyc(8'd77);
        cyc(8'd78);
        check("resume_err",       err,       0);
        check("resume_evt_valid", evt_valid, 0);

        // Dropping enable returns to IDLE; re-entry needs a fresh SYNC.
        enable = 1'b0;
        cyc(8'd79);
        enable = 1'b1;
        cyc(8'd5);
        cyc(8'd33);
        cyc(8'd34);
        check("reenable_err", err, 0);
        exp_q.push_back(ev(ERR, 8'd90));
        cyc(8'd90);
        check("reenable_err_set",   err,       1);
        check("reenable_err_count", err_count, 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event queue depth (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port count  input  8  registered count from the upstream 8-bit counter.
REQ-005 SHALL have port cnt_reset  input  1  the counter's synchronous reset, same clock.
REQ-006 SHALL have port enable  input  1  monitoring enable, level.
REQ-007 SHALL have port threshold  input  8  hit value, sampled every cycle.
REQ-008 SHALL have port clr  input  1  pulse; clears sticky status and flushes queue.
REQ-009 SHALL have port evt_valid  output  1  queue non-empty.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts head event.
REQ-011 SHALL have port evt_data  output  10  {code[1:0], count[7:0]} of head event.
REQ-012 SHALL have port err  output  1  sticky sequence-error flag.
REQ-013 SHALL have port err_count  output  8  saturating error total.
REQ-014 SHALL have port overflow  output  1  sticky: event dropped on full queue.

Function
REQ-015 SHALL implement FSM IDLE -> SYNC -> TRACK; enable=0 forces IDLE from any state next edge.
REQ-016 SHALL in IDLE with enable=1 go to SYNC; SYNC captures prev=count, no check, then TRACK.
REQ-017 SHALL register cnt_reset into rst_q each edge; in TRACK expected = rst_q ? 0 : prev+1 mod 256.
REQ-018 SHALL in TRACK, count != expected: raise ERR event, set err, err_count+1 saturating at 255, prev=count (resync).
REQ-019 SHALL in TRACK, prev==255, count==0, rst_q==0: raise WRAP event.
REQ-020 SHALL in TRACK, count==threshold and prev!=threshold: raise HIT event (once per arrival).
REQ-021 SHALL push at most one event per cycle, priority ERR(2) > WRAP(1) > HIT(0); lower ones discarded.
REQ-022 SHALL update prev=count every TRACK cycle.
REQ-023 SHALL enqueue {code, count}; push latency 1 cycle (evt_valid visible the edge after detection).
REQ-024 SHALL pop head when evt_valid && evt_ready; evt_data stable while evt_valid && !evt_ready.
REQ-025 SHALL on push to full queue without pop drop the event and set overflow; push+pop when full both succeed.
REQ-026 SHALL on push+pop when empty leave queue empty-to-one correctly (no bypass; event appears next cycle).
REQ-027 SHALL on clr: clear err, err_count, overflow, flush queue; clr wins over a same-cycle push and pop.
REQ-028 SHALL not alter FSM state on clr.

Reset
REQ-029 SHALL on reset_n=0 immediately set state=IDLE, prev=0, rst_q=0, queue empty, evt_valid=0, evt_data=0, err=0, err_count=0, overflow=0.
REQ-030 SHALL treat reset_n assertion mid-transfer as discarding all queued events; no partial outputs.

Structure
REQ-031 SHALL place state enum (IDLE, SYNC, TRACK), event code enum (HIT, WRAP, ERR) and event width constant in package count_mon_pkg.
REQ-032 SHALL implement the queue as sub-module evt_fifo (parameter depth/width, push, pop, flush, full, empty).

Verification
REQ-033 SHALL: enable=1, counter free-runs from reset, threshold=5 -> exactly one HIT with evt_data={0,5}, err=0.
REQ-034 SHALL: counter runs 0..255..0 -> one WRAP {1,0}; cnt_reset pulse at count=100 -> next count 0, no ERR.
REQ-035 SHALL: force count 10->12 in TRACK -> ERR {2,12}, err=1, err_count=1; 300 forced errors -> err_count=255.
REQ-036 SHALL: evt_ready=0, generate 5 events with depth 4 -> 4 queued in order, overflow=1; then evt_ready=1 drains 4.
REQ-037 SHALL: clr coincident with ERR detection -> queue empty, err=0, err_count=0 next cycle.
REQ-038 SHALL: reset_n low mid-operation with 3 queued events -> evt_valid=0 immediately, state IDLE; resume requires SYNC cycle.
